run_transmitter: RTL
====================

# run_transmitter

Serial run-length transmitter: accepts commands of the form "drive bit B for N cycles" over a valid/ready handshake and emits them as a single-bit stream on `w`, one bit per clock. It is the stimulus-side counterpart of the team's run-detecting state machines. It produces the `w` stream those detectors consume, so long runs of 0s or 1s can be generated on chip instead of hand-sequenced. A one-entry holding slot lets the next command queue while the current run is on the wire.

## Interface
- `LEN_W`, default 3: width of `cmd_len`; maximum run is 2^LEN_W cycles.
- `IDLE_BIT`, default 1'b0: value driven on `w` when no run is active.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: slot empty; a transfer occurs on the rising edge where `cmd_valid & cmd_ready`.
- `cmd_bit` in 1: bit value for the run.
- `cmd_len` in LEN_W: run length; 0 encodes 2^LEN_W.
- `w` out 1: serial output, registered.
- `busy` out 1: run active, guard cycle, or slot occupied.
- `done` out 1: one-cycle pulse after the last bit of each completed run.
- `state` out 3: FSM state encoding, exposed for debug and bench checks.

## Operation
- States: IDLE=3'b000, SEND=3'b001, GUARD=3'b010. All other encodings are illegal and go to IDLE on the next edge.
- Slot: one register set holding {bit, len, valid}.
  - `cmd_ready = ~slot_valid & ~reset`. No combinational path from `cmd_valid`.
- Active run registers: `act_bit`, down-counter `cnt` (LEN_W+1 bits), both loaded from the slot.
  - `cmd_len==0` loads `cnt = 2^LEN_W`.
- IDLE: if `slot_valid`, load active from slot, clear slot, set `w<=slot bit`, `cnt<=len`, and go to SEND. Otherwise `w<=IDLE_BIT`.
- SEND: decrement `cnt` each cycle. When `cnt==1` at the edge:
  - Assert `done` (registered; high for the following cycle).
  - With the guard feature: go to GUARD and set `w<=~act_bit`.
  - Without it: if `slot_valid`, load the next command with no gap (`w<=next bit`, stay in SEND). Otherwise go to IDLE with `w<=IDLE_BIT`.
- GUARD: lasts exactly one cycle. Then, if `slot_valid`, load the next command and go to SEND. Otherwise go to IDLE with `w<=IDLE_BIT`.
- Simultaneous events:
  - A slot fill and a slot drain cannot occur on the same edge, because `cmd_ready` is low while the slot is full.
  - `cmd_ready` rises the cycle after the slot drains.
- Reset, including mid-run, on the edge with `reset=1`:
  - `state`=IDLE, `w`=IDLE_BIT, `done`=0, `busy`=0, slot cleared, `cnt`=0.
  - Any in-flight run is truncated with no `done` pulse.
  - Commands presented during reset are dropped.
- `busy = (state!=IDLE) | slot_valid`.

## Timing
- Accept at edge t: first bit on `w` after edge t+1. The bit is held for exactly N cycles, through edge t+N.
- `done` is high during the cycle after the last bit. That cycle is the guard cycle, the first bit of the next run, or the first idle cycle.
- Back-to-back runs without the guard feature are gapless. With it, exactly one guard cycle separates runs.
- Sustained throughput without the guard feature: N cycles per command for any N ≥ 2. For N=1 the rate is bounded by the slot, at 1 command per 2 cycles.
- Reset values: `w`=IDLE_BIT, `cmd_ready`=0 during reset and 1 on the first cycle after, `busy`=0, `done`=0, `state`=3'b000.

## Configuration
- `RUN_TX_GUARD_EN` defined:
  - The GUARD state exists.
  - After every run, one cycle of `~act_bit` is driven on `w`. This guarantees a downstream run detector sees the run boundary even when consecutive commands share the same bit.
- Not defined:
  - The GUARD state is not implemented. Encoding 3'b010 is unreachable.
  - Consecutive same-bit commands merge into one longer run on `w`.

## Structure
- Package `run_tx_pkg`: state encodings (ST_IDLE, ST_SEND, ST_GUARD) and the 3-bit state typedef.
- Sub-module `run_tx_slot`: the one-entry {bit, len} holding register with valid/ready, load, and clear. It has its own synchronous reset.
- Top level: FSM, counter, and the `w`/`done` output registers.

## Test plan
- Reset, then accept bit=1, len=4 (no macro):
  - `w`=1 on exactly 4 consecutive cycles starting 2 edges after accept.
  - `done` high the next cycle.
  - `state` returns to 3'b000; `w` returns to 0.
- Back-to-back {1,3} then {0,2}:
  - Without the macro: `w`=1,1,1,0,0 with no gap.
  - With `RUN_TX_GUARD_EN`: `w`=1,1,1,0(guard),0,0.
  - `done` pulses twice.
- `cmd_len=0` with LEN_W=3: `w` holds `cmd_bit` for exactly 8 cycles.
- `cmd_valid` held high with 3 queued commands {1,2},{1,2},{0,2}:
  - `cmd_ready` low while the slot is full.
  - All 3 runs appear in order; none are lost or duplicated.
  - With the macro, the same-bit runs are split by a 0 guard.
- Reset asserted on the 3rd bit of a len=6 run with a slot loaded:
  - Next cycle `w`=IDLE_BIT, `busy`=0, no `done`.
  - The queued command is never transmitted.
- `IDLE_BIT=1`, one command {0,2}:
  - `w` idles at 1, goes 0,0, then returns to 1.

Source files
------------

// File: rtl/run_tx_pkg.sv
// rtl/run_tx_pkg.sv - State encodings shared by the run-length transmitter files
package run_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_SEND  = 3'b001,
        ST_GUARD = 3'b010
    } state_t;

endpackage

// File: rtl/run_tx_slot.sv
// rtl/run_tx_slot.sv - One-entry {bit, len} command holding slot with valid/ready
module run_tx_slot #(
    parameter int LEN_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_bit,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             clear,
    output logic             slot_valid,
    output logic             slot_bit,
    output logic [LEN_W-1:0] slot_len
);

    // Ready depends only on the registered valid, never on cmd_valid
    assign cmd_ready = ~slot_valid & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid <= 1'b0;
            slot_bit   <= 1'b0;
            slot_len   <= '0;
        end else if (cmd_valid && cmd_ready) begin
            slot_valid <= 1'b1;
            slot_bit   <= cmd_bit;
            slot_len   <= cmd_len;
        end else if (clear) begin
            slot_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/run_transmitter.sv
// rtl/run_transmitter.sv - Run-length serial transmitter: FSM, run counter, w/done registers.
// Optional one-cycle inverted guard bit between runs under RUN_TX_GUARD_EN.
module run_transmitter
    import run_tx_pkg::*;
#(
    parameter int   LEN_W    = 3,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_bit,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             w,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state
);

    localparam logic [LEN_W:0] CNT_MAX = {1'b1, {LEN_W{1'b0}}};
    localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [LEN_W:0]   cnt_q, cnt_d;
    logic             w_q, w_d;
    logic             done_q, done_d;
    logic             take;
    logic             fetch;
    logic             slot_valid;
    logic             slot_bit;
    logic [LEN_W-1:0] slot_len;
    logic [LEN_W:0]   load_cnt;
`ifdef RUN_TX_GUARD_EN
    logic             act_bit_q, act_bit_d;
`endif

    run_tx_slot #(.LEN_W(LEN_W)) u_slot (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_bit    (cmd_bit),
        .cmd_len    (cmd_len),
        .clear      (take),
        .slot_valid (slot_valid),
        .slot_bit   (slot_bit),
        .slot_len   (slot_len)
    );

    // A zero length field encodes the longest run
    assign load_cnt = (slot_len == '0) ? CNT_MAX : {1'b0, slot_len};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        done_d  = 1'b0;
        take    = 1'b0;
        fetch   = 1'b0;
`ifdef RUN_TX_GUARD_EN
        act_bit_d = act_bit_q;
`endif
        case (state_q)
            ST_IDLE: fetch = 1'b1;
            ST_SEND: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    done_d = 1'b1;
`ifdef RUN_TX_GUARD_EN
                    state_d = ST_GUARD;
                    w_d     = ~act_bit_q;
`else
                    fetch   = 1'b1;
`endif
                end
            end
`ifdef RUN_TX_GUARD_EN
            ST_GUARD: fetch = 1'b1;
`endif
            default: begin
                state_d = ST_IDLE;
                w_d     = IDLE_BIT;
            end
        endcase

        // Start the queued command, or fall back to idling
        if (fetch) begin
            if (slot_valid) begin
                take    = 1'b1;
                state_d = ST_SEND;
                w_d     = slot_bit;
                cnt_d   = load_cnt;
`ifdef RUN_TX_GUARD_EN
                act_bit_d = slot_bit;
`endif
            end else begin
                state_d = ST_IDLE;
                w_d     = IDLE_BIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            w_q     <= IDLE_BIT;
            done_q  <= 1'b0;
`ifdef RUN_TX_GUARD_EN
            act_bit_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            done_q  <= done_d;
`ifdef RUN_TX_GUARD_EN
            act_bit_q <= act_bit_d;
`endif
        end
    end

    assign w     = w_q;
    assign done  = done_q;
    assign state = state_q;
    assign busy  = (state_q != ST_IDLE) | slot_valid;

endmodule
